// File: rtl/usb_fe_rx.sv
// USB 2.0 Full-Speed device receive front end: line synchronizer, bit clock
// recovery, NRZI decode, bit unstuffing, SYNC/EOP detection and bus reset.
module usb_fe_rx #(
   parameter int CLK_PER_BIT  = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int RESET_CYCLES = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dp,
   input  logic       dn,
   input  logic       rx_en,
   output logic [1:0] line_state,
   output logic       rx_active,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_eop,
   output logic       rx_err,
   output logic       bus_reset
);

   localparam int PW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_PER_BIT - 1);
   localparam logic [PW-1:0] PH_SAMP = PW'(CLK_PER_BIT / 2 - 1);
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_J   = 2'b01;
   localparam logic [1:0] LS_K   = 2'b10;
   localparam logic [1:0] LS_SE1 = 2'b11;
   localparam logic [7:0] SYNC_PAT = 8'hAB; // K J K J K J K K, oldest in MSB, K = 1

   typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] dp_sync_q, dp_sync_d, dn_sync_q, dn_sync_d;
   logic [SYNC_STAGES:0]   dp_shift, dn_shift;
   logic [1:0]             line_prev_q, line_prev_d;
   logic [1:0]             prev_samp_q, prev_samp_d;
   logic [PW-1:0]          phase_q, phase_d;
   logic [7:0]             hist_q, hist_d;
   logic [2:0]             ones_q, ones_d;
   logic [2:0]             bitcnt_q, bitcnt_d;
   logic [7:0]             byte_q, byte_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_active_q, rx_active_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   rx_eop_q, rx_eop_d;
   logic                   rx_err_q, rx_err_d;
   logic [RW-1:0]          se0_cnt_q, se0_cnt_d;
   logic                   change, samp, bit_one, is_jk;

   assign dp_shift   = {dp_sync_q, dp};
   assign dn_shift   = {dn_sync_q, dn};
   assign line_state = {dn_sync_q[SYNC_STAGES-1], dp_sync_q[SYNC_STAGES-1]};
   assign rx_active  = rx_active_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign rx_eop     = rx_eop_q;
   assign rx_err     = rx_err_q;
   assign bus_reset  = (se0_cnt_q == RW'(RESET_CYCLES));

   always_comb begin
      dp_sync_d   = dp_shift[SYNC_STAGES-1:0];
      dn_sync_d   = dn_shift[SYNC_STAGES-1:0];
      line_prev_d = line_state;
      change      = (line_state != line_prev_q);
      phase_d     = (change || phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      samp        = (phase_q == PH_SAMP) && !change;
      bit_one     = (line_state == prev_samp_q);
      is_jk       = (line_state == LS_J) || (line_state == LS_K);

      state_d     = state_q;
      prev_samp_d = prev_samp_q;
      hist_d      = hist_q;
      ones_d      = ones_q;
      bitcnt_d    = bitcnt_q;
      byte_d      = byte_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      rx_eop_d    = 1'b0;
      rx_err_d    = 1'b0;

      if (line_state != LS_SE0) se0_cnt_d = '0;
      else if (se0_cnt_q == RW'(RESET_CYCLES)) se0_cnt_d = se0_cnt_q;
      else se0_cnt_d = se0_cnt_q + RW'(1);

      if (!rx_en) begin
         state_d = IDLE;
         hist_d  = '0;
      end else if (samp) begin
         unique case (state_q)
            IDLE, SYNC: begin
               if (is_jk) begin
                  hist_d      = {hist_q[6:0], line_state == LS_K};
                  prev_samp_d = line_state;
                  if (state_q == SYNC && hist_d == SYNC_PAT) begin
                     state_d  = DATA;
                     ones_d   = 3'd1;
                     bitcnt_d = '0;
                     hist_d   = '0;
                  end else if (state_q == IDLE && line_state == LS_K) begin
                     state_d = SYNC;
                  end
               end else begin
                  hist_d  = '0;
                  state_d = IDLE;
               end
            end
            DATA: begin
               if (line_state == LS_SE1) begin
                  rx_err_d = 1'b1;
                  state_d  = IDLE;
               end else if (line_state == LS_SE0) begin
                  if (bitcnt_q != '0) begin
                     rx_err_d = 1'b1;
                     state_d  = IDLE;
                  end else begin
                     state_d = EOP;
                  end
               end else begin
                  prev_samp_d = line_state;
                  if (ones_q == 3'd6) begin
                     // stuffed bit: must be a 0 and never reaches the byte register
                     if (bit_one) begin
                        rx_err_d = 1'b1;
                        state_d  = IDLE;
                     end else begin
                        ones_d = '0;
                     end
                  end else begin
                     ones_d = bit_one ? ones_q + 3'd1 : '0;
                     byte_d = {bit_one, byte_q[7:1]};
                     if (bitcnt_q == 3'd7) begin
                        rx_data_d  = byte_d;
                        rx_valid_d = 1'b1;
                        bitcnt_d   = '0;
                     end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                     end
                  end
               end
            end
            EOP: begin
               if (line_state == LS_J) begin
                  rx_eop_d = 1'b1;
                  state_d  = IDLE;
               end else if (line_state != LS_SE0) begin
                  rx_err_d = 1'b1;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (state_d == IDLE) prev_samp_d = LS_J;
      rx_active_d = (state_d == DATA) || (state_d == EOP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         dp_sync_q   <= '1;
         dn_sync_q   <= '0;
         line_prev_q <= LS_J;
         prev_samp_q <= LS_J;
         phase_q     <= '0;
         hist_q      <= '0;
         ones_q      <= '0;
         bitcnt_q    <= '0;
         byte_q      <= '0;
         rx_data_q   <= '0;
         rx_active_q <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_eop_q    <= 1'b0;
         rx_err_q    <= 1'b0;
         se0_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         dp_sync_q   <= dp_sync_d;
         dn_sync_q   <= dn_sync_d;
         line_prev_q <= line_prev_d;
         prev_samp_q <= prev_samp_d;
         phase_q     <= phase_d;
         hist_q      <= hist_d;
         ones_q      <= ones_d;
         bitcnt_q    <= bitcnt_d;
         byte_q      <= byte_d;
         rx_data_q   <= rx_data_d;
         rx_active_q <= rx_active_d;
         rx_valid_q  <= rx_valid_d;
         rx_eop_q    <= rx_eop_d;
         rx_err_q    <= rx_err_d;
         se0_cnt_q   <= se0_cnt_d;
      end
   end

endmodule

// File: tb/tb_usb_fe_rx.sv
// Directed bench for usb_fe_rx: host-side NRZI/stuffing encoder drives dp/dn,
// a negedge monitor logs strobes, and the main sequence checks the log.
module tb_usb_fe_rx;

   localparam logic [1:0] SE0 = 2'b00;
   localparam logic [1:0] J   = 2'b01;
   localparam logic [1:0] K   = 2'b10;

   logic       clk, rst, dp, dn, rx_en;
   logic [1:0] line_state;
   logic       rx_active, rx_valid, rx_eop, rx_err, bus_reset;
   logic [7:0] rx_data;

   int         vec_cnt = 0;
   int         miscmp  = 0;
   int         cyc     = 0;
   int         n_eop   = 0;
   int         n_err   = 0;
   int         err_cyc = -100;
   int         t6;
   logic [7:0] vq[$];
   logic       prev_active = 1'b0;
   logic [1:0] cur;
   int         ones_tx;
   bit         jit = 1'b0;
   bit         jph = 1'b0;

   usb_fe_rx #(.CLK_PER_BIT(4), .SYNC_STAGES(2), .RESET_CYCLES(120)) dut (
      .clk(clk), .rst(rst), .dp(dp), .dn(dn), .rx_en(rx_en),
      .line_state(line_state), .rx_active(rx_active), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_eop(rx_eop), .rx_err(rx_err), .bus_reset(bus_reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      assert (got === exp) else begin
         miscmp++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid) vq.push_back(rx_data);
      if (rx_eop) n_eop++;
      if (rx_err) begin
         n_err++;
         err_cyc = cyc;
      end
      if (rx_valid || rx_eop || rx_err)
         check("strobe_excl", int'(rx_valid) + int'(rx_eop) + int'(rx_err), 1);
      if (rx_eop || rx_err) begin
         check("active_low_at_end", {31'b0, rx_active}, 0);
         check("active_high_before_end", {31'b0, prev_active}, 1);
      end
      prev_active = rx_active;
   end

   function automatic int bdur();
      if (!jit) return 4;
      jph = !jph;
      return jph ? 3 : 5;
   endfunction

   task automatic drive(input logic [1:0] ls, input int n);
      dp = ls[0];
      dn = ls[1];
      repeat (n) @(negedge clk);
   endtask

   task automatic raw_bit(input bit b);
      if (!b) cur = (cur == J) ? K : J;
      drive(cur, bdur());
   endtask

   task automatic tx_sync();
      cur = J;
      for (int i = 0; i < 7; i++) raw_bit(1'b0);
      raw_bit(1'b1);
      ones_tx = 1;
   endtask

   task automatic tx_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         raw_bit(b[i]);
         ones_tx = b[i] ? ones_tx + 1 : 0;
         if (ones_tx == 6) begin
            raw_bit(1'b0);
            ones_tx = 0;
         end
      end
   endtask

   task automatic tx_eop();
      drive(SE0, bdur() + bdur());
      cur = J;
      drive(J, 16);
   endtask

   initial begin
      rst = 1'b1; rx_en = 1'b1; dp = 1'b1; dn = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_rx_active", {31'b0, rx_active}, 0);
      check("rst_rx_valid", {31'b0, rx_valid}, 0);
      check("rst_rx_eop", {31'b0, rx_eop}, 0);
      check("rst_rx_err", {31'b0, rx_err}, 0);
      check("rst_rx_data", {24'b0, rx_data}, 0);
      check("rst_bus_reset", {31'b0, bus_reset}, 0);
      check("rst_line_state", {30'b0, line_state}, 32'h1);
      rst = 1'b0;
      drive(J, 20);

      // clean SETUP token
      tx_sync();
      tx_byte(8'h2D);
      check("tok_active", {31'b0, rx_active}, 1);
      tx_byte(8'h00);
      tx_byte(8'h10);
      tx_eop();
      check("tok_nvalid", vq.size(), 3);
      check("tok_b0", {24'b0, vq[0]}, 32'h2D);
      check("tok_b1", {24'b0, vq[1]}, 32'h00);
      check("tok_b2", {24'b0, vq[2]}, 32'h10);
      check("tok_eop", n_eop, 1);
      check("tok_err", n_err, 0);
      check("tok_active_after", {31'b0, rx_active}, 0);

      // stuffed 0 after six ones (sync final bit counts as the first)
      tx_sync();
      tx_byte(8'hFF);
      tx_byte(8'h01);
      tx_eop();
      check("stuff_nvalid", vq.size(), 5);
      check("stuff_b0", {24'b0, vq[3]}, 32'hFF);
      check("stuff_b1", {24'b0, vq[4]}, 32'h01);
      check("stuff_eop", n_eop, 2);
      check("stuff_err", n_err, 0);

      // stuff violation: line held at K after SYNC
      tx_sync();
      for (int i = 0; i < 5; i++) raw_bit(1'b1);
      t6 = cyc;
      raw_bit(1'b1);
      drive(cur, 8);
      check("stufferr_err", n_err, 1);
      check("stufferr_timing", {31'b0, (err_cyc >= t6 + 2) && (err_cyc <= t6 + 7)}, 1);
      check("stufferr_nvalid", vq.size(), 5);
      cur = J;
      drive(J, 20);

      // SE0 arrives with a partial byte
      tx_sync();
      tx_byte(8'hA5);
      raw_bit(1'b1); raw_bit(1'b0); raw_bit(1'b1); raw_bit(1'b0); raw_bit(1'b1);
      tx_eop();
      check("mis_nvalid", vq.size(), 6);
      check("mis_b0", {24'b0, vq[5]}, 32'hA5);
      check("mis_err", n_err, 2);
      check("mis_eop", n_eop, 2);

      // 3/5 clock bit periods, then abort by rx_en mid-byte
      jit = 1'b1;
      jph = 1'b0;
      tx_sync();
      tx_byte(8'hC3);
      raw_bit(1'b0); raw_bit(1'b1); raw_bit(1'b0);
      check("jit_active", {31'b0, rx_active}, 1);
      rx_en = 1'b0;
      @(negedge clk);
      check("abort_active", {31'b0, rx_active}, 0);
      raw_bit(1'b1); raw_bit(1'b0); raw_bit(1'b1); raw_bit(1'b1); raw_bit(1'b0);
      jit = 1'b0;
      cur = J;
      drive(J, 20);
      rx_en = 1'b1;
      drive(J, 8);
      check("jit_nvalid", vq.size(), 7);
      check("jit_b0", {24'b0, vq[6]}, 32'hC3);
      check("abort_err", n_err, 2);
      check("abort_eop", n_eop, 2);

      // synchronous reset mid-packet
      tx_sync();
      raw_bit(1'b1); raw_bit(1'b0); raw_bit(1'b1);
      check("rstmid_active_pre", {31'b0, rx_active}, 1);
      rst = 1'b1; dp = 1'b1; dn = 1'b0; cur = J;
      @(negedge clk);
      check("rstmid_active", {31'b0, rx_active}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drive(J, 20);
      check("rstmid_nvalid", vq.size(), 7);
      check("rstmid_err", n_err, 2);
      check("rstmid_eop", n_eop, 2);
      check("rstmid_line", {30'b0, line_state}, 32'h1);

      // bus reset: SE0 held 200 clocks
      dp = 1'b0; dn = 1'b0;
      repeat (121) @(negedge clk);
      check("busrst_line_se0", {30'b0, line_state}, 0);
      check("busrst_not_yet", {31'b0, bus_reset}, 0);
      @(negedge clk);
      check("busrst_high", {31'b0, bus_reset}, 1);
      repeat (78) @(negedge clk);
      dp = 1'b1;
      repeat (2) @(negedge clk);
      check("busrst_hold", {31'b0, bus_reset}, 1);
      @(negedge clk);
      check("busrst_clear", {31'b0, bus_reset}, 0);
      check("busrst_no_err", n_err, 2);
      drive(J, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

endmodule
